// File: rtl/axis_cfg_pkg.sv
// axis_cfg_pkg
// Shared definitions for the axis config-bus command scheduler:
//   - state_t      : scheduler FSM state encoding
//   - SEL_*_CODE   : low bit of the select word, choosing address or length
//   - DEF_*        : default config register addresses and channel ids
//   - sel_word()   : builds the {id, sel} select word written to CONFIG_ADDR
package axis_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL_A = 3'd1,
        S_VAL_A = 3'd2,
        S_SEL_L = 3'd3,
        S_VAL_L = 3'd4
    } state_t;

    localparam logic SEL_ADDR_CODE = 1'b0;
    localparam logic SEL_LEN_CODE  = 1'b1;

    localparam int DEF_CONFIG_ADDR  = 0;
    localparam int DEF_CONFIG_DATA  = 1;
    localparam int DEF_CONFIG_ID_RD = 1;
    localparam int DEF_CONFIG_ID_WR = 2;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // The select word is the channel id shifted up by one with the
    // address/length select in bit 0.
    function automatic logic [31:0] sel_word(input int id, input logic sel);
        logic [31:0] id_bits;
        id_bits = id;
        return {id_bits[30:0], sel};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with an internal last-grant pointer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : NREQ request lines
//   enable      : when high, a pending request is granted this cycle
//   grant       : one-hot grant, only non-zero while enable is high
//   grant_idx   : index of the winning request (meaningful when grant != 0)
// The pointer resets to NREQ-1 so requester 0 wins first, and only moves
// when a grant is actually issued.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               cand;

    // Search starts one past the last winner and wraps around, so every
    // requester is reached within NREQ grants.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end
        ptr_d = (enable && found) ? grant_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axis_cfg_sched.sv
// axis_cfg_sched
// Serialises host config writes and requester commands onto a single
// registered axis config bus (cfg_addr/cfg_data/cfg_valid, no backpressure).
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   host_addr/host_data/host_valid  : host config write, accepted when host_ready
//   host_ready                      : high only while idle
//   req_dir/req_addr/req_len        : per-requester command (flattened 32-bit fields)
//   req_valid/req_ready             : command handshake, req_ready one-hot pulse
//   cfg_addr/cfg_data/cfg_valid     : registered config beats
//   busy                            : four-beat command sequence in progress
//   drop_cnt                        : saturating count of zero-length commands
// A command becomes four beats: select address slot, write address, select
// length slot, write length. Host writes only go out from idle, so they can
// never land in the middle of a command.
module axis_cfg_sched
    import axis_cfg_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int CFG_AWIDTH   = 5,
    parameter int CFG_DWIDTH   = 32,
    parameter int CONFIG_ADDR  = DEF_CONFIG_ADDR,
    parameter int CONFIG_DATA  = DEF_CONFIG_DATA,
    parameter int CONFIG_ID_RD = DEF_CONFIG_ID_RD,
    parameter int CONFIG_ID_WR = DEF_CONFIG_ID_WR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CFG_AWIDTH-1:0] host_addr,
    input  logic [CFG_DWIDTH-1:0] host_data,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [NREQ-1:0]       req_dir,
    input  logic [NREQ*32-1:0]    req_addr,
    input  logic [NREQ*32-1:0]    req_len,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic                  cfg_valid,
    output logic                  busy,
    output logic [15:0]           drop_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CFG_AWIDTH-1:0] SEL_REG = CFG_AWIDTH'(CONFIG_ADDR);
    localparam logic [CFG_AWIDTH-1:0] VAL_REG = CFG_AWIDTH'(CONFIG_DATA);

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           len_q, len_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic [CFG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [CFG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic                  arb_enable;
    logic [NREQ-1:0]       arb_grant;
    logic [IDX_W-1:0]      arb_idx;

    logic [31:0]           req_addr_a [NREQ];
    logic [31:0]           req_len_a  [NREQ];

    function automatic logic [CFG_DWIDTH-1:0] sel_beat(input logic dir, input logic sel);
        return CFG_DWIDTH'(sel_word(dir ? CONFIG_ID_RD : CONFIG_ID_WR, sel));
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr_a[i] = req_addr[32*i +: 32];
            req_len_a[i]  = req_len[32*i +: 32];
        end
    end

    // Requesters are only considered when idle and the host is not writing;
    // rst_n gates the enable so no req_ready pulse escapes during reset.
    assign arb_enable = (state_q == S_IDLE) && !host_valid && rst_n;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .enable   (arb_enable),
        .grant    (arb_grant),
        .grant_idx(arb_idx)
    );

    // Each state's entry beat is prepared one cycle ahead so it leaves the
    // register exactly while the FSM sits in that state.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cfg_valid_d = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
        drop_cnt_d  = drop_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (host_valid) begin
                    cfg_valid_d = 1'b1;
                    cfg_addr_d  = host_addr;
                    cfg_data_d  = host_data;
                end else if (|arb_grant) begin
                    if (req_len_a[arb_idx] == 32'd0) begin
                        if (drop_cnt_q != DROP_CNT_MAX) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end else begin
                        dir_d       = req_dir[arb_idx];
                        addr_d      = req_addr_a[arb_idx];
                        len_d       = req_len_a[arb_idx];
                        cfg_valid_d = 1'b1;
                        cfg_addr_d  = SEL_REG;
                        cfg_data_d  = sel_beat(req_dir[arb_idx], SEL_ADDR_CODE);
                        state_d     = S_SEL_A;
                    end
                end
            end
            S_SEL_A: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = VAL_REG;
                cfg_data_d  = CFG_DWIDTH'(addr_q);
                state_d     = S_VAL_A;
            end
            S_VAL_A: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = SEL_REG;
                cfg_data_d  = sel_beat(dir_q, SEL_LEN_CODE);
                state_d     = S_SEL_L;
            end
            S_SEL_L: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = VAL_REG;
                cfg_data_d  = CFG_DWIDTH'(len_q);
                state_d     = S_VAL_L;
            end
            S_VAL_L: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign host_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign req_ready  = arb_grant;
    assign cfg_valid  = cfg_valid_q;
    assign cfg_addr   = cfg_addr_q;
    assign cfg_data   = cfg_data_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
